// File: rtl/mem_port_arbiter_pkg.sv
// Package mips_mem_pkg
//  Constants and helpers shared by the fetch stage, the memory model and the
//  memory port arbiter:
//   - burst size codes and the beats() decode (unknown codes decode to 1 beat)
//   - access direction constants
//   - arbiter state encoding
package mips_mem_pkg;

  // Burst size codes carried on *_access_size
  localparam logic [2:0] SIZE_1  = 3'b000;
  localparam logic [2:0] SIZE_4  = 3'b001;
  localparam logic [2:0] SIZE_8  = 3'b010;
  localparam logic [2:0] SIZE_16 = 3'b011;
  localparam logic [2:0] SIZE_32 = 3'b100;

  // Direction on mem_rw / d_rw
  localparam logic ACCESS_READ  = 1'b0;
  localparam logic ACCESS_WRITE = 1'b1;

  // Wide enough to hold the largest burst length (32)
  localparam int BEAT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } arb_state_t;

  // Number of beats in a burst; reserved codes behave as a single beat
  function automatic logic [BEAT_W-1:0] beats(input logic [2:0] size);
    logic [BEAT_W-1:0] n;
    case (size)
      SIZE_1:  n = BEAT_W'(1);
      SIZE_4:  n = BEAT_W'(4);
      SIZE_8:  n = BEAT_W'(8);
      SIZE_16: n = BEAT_W'(16);
      SIZE_32: n = BEAT_W'(32);
      default: n = BEAT_W'(1);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Interface mem_port_arbiter_if
//  Bundles the fetch port, data port and memory-side signals of the memory
//  port arbiter.
//   slave  : arbiter view (requests/mem_busy in; busy lines and mem_* out)
//   master : environment view (fetch stage, mem stage and memory model)
//  Signals:
//   if_req/if_addr/if_access_size/if_busy      fetch (read-only) port
//   d_req/d_addr/d_rw/d_access_size/d_busy     data port
//   mem_addr/mem_rw/mem_access_size/mem_enable memory command
//   mem_busy                                   memory stall
//   grant_d                                    data port owns memory
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [2:0]        if_access_size;
  logic              if_busy;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_rw;
  logic [2:0]        d_access_size;
  logic              d_busy;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rw;
  logic [2:0]        mem_access_size;
  logic              mem_enable;
  logic              mem_busy;
  logic              grant_d;

  modport slave (
    input  if_req, if_addr, if_access_size,
    input  d_req, d_addr, d_rw, d_access_size,
    input  mem_busy,
    output if_busy, d_busy,
    output mem_addr, mem_rw, mem_access_size, mem_enable, grant_d
  );

  modport master (
    output if_req, if_addr, if_access_size,
    output d_req, d_addr, d_rw, d_access_size,
    output mem_busy,
    input  if_busy, d_busy,
    input  mem_addr, mem_rw, mem_access_size, mem_enable, grant_d
  );

endinterface

// File: rtl/mem_port_arbiter_beat_counter.sv
// Module arb_beat_counter
//  Tracks the beats remaining in the current burst.
//  Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   load         start of a new burst (takes priority over accept)
//   load_size    burst size code of the new burst
//   accept       a beat was accepted by memory this cycle
//   last_beat    the beat accepted this cycle is the final one of the burst
module arb_beat_counter
  import mips_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] load_size,
  input  logic       accept,
  output logic       last_beat
);

  logic [BEAT_W-1:0] beats_left_reg;
  logic [BEAT_W-1:0] beats_left_next;

  // A load on the final beat of the previous burst overwrites the decrement,
  // which is what lets bursts run back-to-back.
  always_comb begin
    beats_left_next = beats_left_reg;
    if (load) begin
      beats_left_next = beats(load_size);
    end else if (accept && (beats_left_reg != '0)) begin
      beats_left_next = beats_left_reg - BEAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_left_reg <= '0;
    end else begin
      beats_left_reg <= beats_left_next;
    end
  end

  assign last_beat = accept && (beats_left_reg == BEAT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Module mem_port_arbiter
//  Shares single-ported main memory between the fetch (instruction) port and
//  the data port. One requester owns memory per burst; the grant is held until
//  the final beat is accepted, and a fresh arbitration on that final beat lets
//  the next burst start without an idle cycle. Data normally wins a tie, but a
//  fetch that has waited STARVE_LIMIT cycles is given priority.
//  Parameters:
//   STARVE_LIMIT  fetch wait cycles before fetch beats a data request (>= 1)
//   ADDR_W        address width
//  Ports:
//   clk, rst_n    clock / asynchronous active-low reset
//   bus           mem_port_arbiter_if slave view (fetch, data, memory sides)
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_t          state_reg,  state_next;
  logic [STARVE_W-1:0] starve_reg, starve_next;
  logic [ADDR_W-1:0]   addr_reg,   addr_next;
  logic                rw_reg,     rw_next;
  logic [2:0]          size_reg,   size_next;

  logic accept;
  logic last_beat;
  logic arb_point;
  logic fetch_forced;
  logic load;

  // Memory is driven whenever a port owns it, so accept is simply "not stalled".
  assign accept    = (state_reg != ST_IDLE) && !bus.mem_busy;
  assign arb_point = (state_reg == ST_IDLE) || last_beat;

  // Fetch overrides data only while it is actually asking.
  assign fetch_forced = bus.if_req && (starve_reg >= STARVE_MAX);

  arb_beat_counter u_beat_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_size (size_next),
    .accept    (accept),
    .last_beat (last_beat)
  );

  // Next state, latched command and burst load
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    rw_next    = rw_reg;
    size_next  = size_reg;
    load       = 1'b0;

    if (arb_point) begin
      if (bus.d_req && !fetch_forced) begin
        state_next = ST_GRANT_D;
        addr_next  = bus.d_addr;
        rw_next    = bus.d_rw;
        size_next  = bus.d_access_size;
        load       = 1'b1;
      end else if (bus.if_req) begin
        state_next = ST_GRANT_I;
        addr_next  = bus.if_addr;
        rw_next    = ACCESS_READ;
        size_next  = bus.if_access_size;
        load       = 1'b1;
      end else begin
        state_next = ST_IDLE;
      end
    end
  end

  // Starvation counter: counts every cycle fetch waits while not owning
  // memory, saturates, and clears when fetch wins an arbitration.
  always_comb begin
    starve_next = starve_reg;
    if (arb_point && (state_next == ST_GRANT_I)) begin
      starve_next = '0;
    end else if (bus.if_req && (state_reg != ST_GRANT_I) && (starve_reg < STARVE_MAX)) begin
      starve_next = starve_reg + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      starve_reg <= '0;
      addr_reg   <= '0;
      rw_reg     <= ACCESS_READ;
      size_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
      addr_reg   <= addr_next;
      rw_reg     <= rw_next;
      size_reg   <= size_next;
    end
  end

  assign bus.mem_enable      = (state_reg != ST_IDLE);
  assign bus.mem_addr        = addr_reg;
  assign bus.mem_rw          = rw_reg;
  assign bus.mem_access_size = size_reg;
  assign bus.grant_d         = (state_reg == ST_GRANT_D);

  // A port is released only in the cycle its final beat is accepted.
  assign bus.if_busy = bus.if_req && !((state_reg == ST_GRANT_I) && last_beat);
  assign bus.d_busy  = bus.d_req  && !((state_reg == ST_GRANT_D) && last_beat);

endmodule
